// File: rtl/ss_return_checker_if.sv
// ---------------------------------------------------------------------------
// ss_return_checker_if
//
// Purpose: bundles the commit-side call/return handshakes, the shadow stack
//          write/read port and the CSR/trap reporting signals of the
//          return-address checker.
//
// Modports:
//   slave  : the checker itself (consumes events, drives the stack port and
//            the violation reporting).
//   master : the surrounding environment (commit stage, shadow stack, CSRs).
//
// Signals:
//   i_call_valid / i_call_addr / o_call_ready : call event handshake
//   i_ret_valid / i_ret_target / o_ret_ready  : return event handshake
//   ss_push / ss_wdata / ss_full              : shadow stack write side
//   ss_pop / ss_rdata / ss_empty              : shadow stack read side
//   i_clear                                   : CSR clear pulse
//   o_violation / o_viol_cause / o_viol_target / o_viol_expected
//   o_overflow / o_viol_cnt                   : reporting to CSR/trap logic
// ---------------------------------------------------------------------------
interface ss_return_checker_if #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
);
    logic              i_call_valid;
    logic [ADDR_W-1:0] i_call_addr;
    logic              o_call_ready;
    logic              i_ret_valid;
    logic [ADDR_W-1:0] i_ret_target;
    logic              o_ret_ready;
    logic              ss_push;
    logic [ADDR_W-1:0] ss_wdata;
    logic              ss_full;
    logic              ss_pop;
    logic [ADDR_W-1:0] ss_rdata;
    logic              ss_empty;
    logic              i_clear;
    logic              o_violation;
    logic [1:0]        o_viol_cause;
    logic [ADDR_W-1:0] o_viol_target;
    logic [ADDR_W-1:0] o_viol_expected;
    logic              o_overflow;
    logic [CNT_W-1:0]  o_viol_cnt;

    modport slave (
        input  i_call_valid, i_call_addr, i_ret_valid, i_ret_target,
        input  ss_full, ss_rdata, ss_empty, i_clear,
        output o_call_ready, o_ret_ready, ss_push, ss_wdata, ss_pop,
        output o_violation, o_viol_cause, o_viol_target, o_viol_expected,
        output o_overflow, o_viol_cnt
    );

    modport master (
        output i_call_valid, i_call_addr, i_ret_valid, i_ret_target,
        output ss_full, ss_rdata, ss_empty, i_clear,
        input  o_call_ready, o_ret_ready, ss_push, ss_wdata, ss_pop,
        input  o_violation, o_viol_cause, o_viol_target, o_viol_expected,
        input  o_overflow, o_viol_cnt
    );
endinterface

// File: rtl/ss_return_checker.sv
// ---------------------------------------------------------------------------
// ss_return_checker
//
// Purpose: control-flow-integrity checker for function returns. Calls push
//          their return address onto the shadow stack; returns are compared
//          against the stack top and then popped. Mismatches and underflows
//          are reported as violations, dropped calls (stack full) as a
//          sticky overflow flag.
//
// Ports:
//   clk    : clock
//   rstn   : synchronous active-low reset, shared with the shadow stack
//   io_bus : ss_return_checker_if.slave (handshakes, stack port, reporting)
//
// Configuration macro:
//   SS_TRAP_HALT_EN  defined   -> VIOL is held until i_clear (blocking trap)
//                    undefined -> VIOL lasts one cycle, o_violation pulses,
//                                 cause/addresses hold until next violation
//                                 or i_clear
// ---------------------------------------------------------------------------
module ss_return_checker #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    ss_return_checker_if.slave    io_bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CMP  = 2'b01,
        ST_VIOL = 2'b10
    } state_t;

    localparam logic [1:0] CAUSE_NONE      = 2'b00;
    localparam logic [1:0] CAUSE_MISMATCH  = 2'b01;
    localparam logic [1:0] CAUSE_UNDERFLOW = 2'b10;

    state_t            r_state;
    state_t            w_next_state;

    logic [ADDR_W-1:0] r_target;
    logic              r_violation;
    logic [1:0]        r_viol_cause;
    logic [ADDR_W-1:0] r_viol_target;
    logic [ADDR_W-1:0] r_viol_expected;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_viol_cnt;

    logic              w_call_ready;
    logic              w_ret_ready;
    logic              w_push;
    logic              w_pop;
    logic [ADDR_W-1:0] w_wdata;
    logic              w_call_accept;
    logic              w_ret_accept;
    logic              w_match;
    logic              w_underflow;
    logic              w_mismatch;
    logic              w_viol_enter;
    logic              w_viol_pulse_end;
    logic              w_call_drop;

    // Saturating increment: the counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] res;
        if (&v) begin
            res = v;
        end else begin
            res = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res;
    endfunction

    assign w_call_accept = w_call_ready & io_bus.i_call_valid;
    assign w_ret_accept  = w_ret_ready & io_bus.i_ret_valid;
    assign w_call_drop   = w_call_accept & io_bus.ss_full;
    assign w_match       = (r_target == io_bus.ss_rdata);
    assign w_underflow   = w_ret_accept & io_bus.ss_empty;
    assign w_mismatch    = (r_state == ST_CMP) & ~w_match;
    assign w_viol_enter  = w_underflow | w_mismatch;

`ifdef SS_TRAP_HALT_EN
    assign w_viol_pulse_end = 1'b0;
`else
    // Non-blocking mode: VIOL is a single cycle, so o_violation drops as
    // the FSM leaves it.
    assign w_viol_pulse_end = (r_state == ST_VIOL);
`endif

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state logic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ret_accept) begin
                    if (io_bus.ss_empty) begin
                        w_next_state = ST_VIOL;
                    end else begin
                        w_next_state = ST_CMP;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_CMP: begin
                if (w_match) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_VIOL;
                end
            end
            ST_VIOL: begin
`ifdef SS_TRAP_HALT_EN
                if (io_bus.i_clear) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_VIOL;
                end
`else
                w_next_state = ST_IDLE;
`endif
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // FSM outputs: handshakes and stack controls. All gated by rstn so that
    // a reset landing in CMP never issues a pop.
    always_comb begin
        w_call_ready = 1'b0;
        w_ret_ready  = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_ret_ready  = rstn;
                // A return wins over a simultaneous call; the call source holds.
                w_call_ready = rstn & ~io_bus.i_ret_valid;
            end
            ST_CMP: begin
                w_pop = rstn;
            end
            ST_VIOL: begin
                w_pop = 1'b0;
            end
            default: begin
                w_pop = 1'b0;
            end
        endcase
        w_push = w_call_ready & io_bus.i_call_valid & ~io_bus.ss_full;
        if (w_push) begin
            w_wdata = io_bus.i_call_addr;
        end else begin
            w_wdata = {ADDR_W{1'b0}};
        end
    end

    // Return target latched on accept, compared during CMP.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_target <= {ADDR_W{1'b0}};
        end else if (w_ret_accept) begin
            r_target <= io_bus.i_ret_target;
        end else begin
            r_target <= r_target;
        end
    end

    // Violation report registers; a new violation takes precedence over a
    // coincident clear so it is never lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_violation     <= 1'b0;
            r_viol_cause    <= CAUSE_NONE;
            r_viol_target   <= {ADDR_W{1'b0}};
            r_viol_expected <= {ADDR_W{1'b0}};
        end else if (w_viol_enter) begin
            r_violation <= 1'b1;
            if (w_mismatch) begin
                r_viol_cause    <= CAUSE_MISMATCH;
                r_viol_target   <= r_target;
                r_viol_expected <= io_bus.ss_rdata;
            end else begin
                r_viol_cause    <= CAUSE_UNDERFLOW;
                r_viol_target   <= io_bus.i_ret_target;
                r_viol_expected <= {ADDR_W{1'b0}};
            end
        end else if (io_bus.i_clear) begin
            r_violation     <= 1'b0;
            r_viol_cause    <= CAUSE_NONE;
            r_viol_target   <= {ADDR_W{1'b0}};
            r_viol_expected <= {ADDR_W{1'b0}};
        end else if (w_viol_pulse_end) begin
            r_violation <= 1'b0;
        end else begin
            r_violation <= r_violation;
        end
    end

    // Saturating violation counter; only reset clears it.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_viol_cnt <= {CNT_W{1'b0}};
        end else if (w_viol_enter) begin
            r_viol_cnt <= sat_inc(r_viol_cnt);
        end else begin
            r_viol_cnt <= r_viol_cnt;
        end
    end

    // Sticky overflow: a call accepted while the stack is full is dropped.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
        end else if (w_call_drop) begin
            r_overflow <= 1'b1;
        end else if (io_bus.i_clear) begin
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= r_overflow;
        end
    end

    assign io_bus.o_call_ready    = w_call_ready;
    assign io_bus.o_ret_ready     = w_ret_ready;
    assign io_bus.ss_push         = w_push;
    assign io_bus.ss_wdata        = w_wdata;
    assign io_bus.ss_pop          = w_pop;
    assign io_bus.o_violation     = r_violation;
    assign io_bus.o_viol_cause    = r_viol_cause;
    assign io_bus.o_viol_target   = r_viol_target;
    assign io_bus.o_viol_expected = r_viol_expected;
    assign io_bus.o_overflow      = r_overflow;
    assign io_bus.o_viol_cnt      = r_viol_cnt;

endmodule

// File: tb/tb_ss_return_checker.sv
// ---------------------------------------------------------------------------
// tb_ss_return_checker
//
// Bench for ss_return_checker with an 8-deep shadow stack fixture. The
// violation counter is built 8 bits wide so saturation is reachable quickly.
// ---------------------------------------------------------------------------
module tb_ss_return_checker;

    localparam int AW = 64;
    localparam int CW = 8;

    logic clk;
    logic rstn;

    ss_return_checker_if #(.ADDR_W(AW), .CNT_W(CW)) bus ();

    ss_return_checker #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shadow stack fixture, DEPTH = 8, top read combinationally.
    logic [AW-1:0] stk [0:7];
    logic [3:0]    sp;

    always @(posedge clk) begin
        if (!rstn) begin
            sp <= 4'd0;
        end else if (bus.ss_push && sp < 4'd8) begin
            stk[sp[2:0]] <= bus.ss_wdata;
            sp <= sp + 4'd1;
        end else if (bus.ss_pop && sp != 4'd0) begin
            sp <= sp - 4'd1;
        end
    end

    assign bus.ss_full  = (sp == 4'd8);
    assign bus.ss_empty = (sp == 4'd0);
    assign bus.ss_rdata = (sp == 4'd0) ? 64'd0 : stk[sp[2:0] - 3'd1];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout, want completion (t=%0t)", name, $time);
    endtask

    // Push and pop must never coincide.
    always @(negedge clk) begin
        if (rstn && (bus.ss_push || bus.ss_pop)) begin
            n_total++;
            if (bus.ss_push && bus.ss_pop) begin
                $display("FAIL push_pop_excl: got push=1 pop=1, want at most one (t=%0t)", $time);
            end else begin
                n_pass++;
            end
        end
    end

    // Reference model: transaction-level view of the checker.
    logic [AW-1:0] mstk[$];
    bit            m_ovf;
    int            m_cnt;
    logic [1:0]    m_cause;
    logic [AW-1:0] m_tgt;
    logic [AW-1:0] m_exp;

    task automatic model_reset();
        mstk.delete();
        m_ovf = 1'b0; m_cnt = 0; m_cause = 2'b00; m_tgt = 64'd0; m_exp = 64'd0;
    endtask

    // All tasks start and end 1 time unit after a rising edge.
    task automatic do_call(input logic [AW-1:0] a, input bit e_push);
        bit ok;
        ok = 1'b0;
        bus.i_call_valid = 1'b1;
        bus.i_call_addr  = a;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (bus.o_call_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            fail_now("call_accept");
        end else begin
            chk("call_push", bus.ss_push, e_push);
            if (e_push) chk("call_wdata", bus.ss_wdata, a);
        end
        @(posedge clk); #1;
        bus.i_call_valid = 1'b0;
    endtask

    task automatic do_ret(input logic [AW-1:0] t, input bit e_pop, input bit e_viol,
                          input logic [1:0] e_cause, input logic [AW-1:0] e_exp);
        int npop;
        bit seen;
        bit ok;
        npop = 0; seen = 1'b0; ok = 1'b0;
        bus.i_ret_valid  = 1'b1;
        bus.i_ret_target = t;
        for (int k = 0; k < 20; k++) begin
            #2;
            if (bus.o_ret_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.i_ret_valid = 1'b0;
        if (!ok) begin
            fail_now("ret_accept");
        end else begin
            ok = 1'b0;
            for (int k = 0; k < 10; k++) begin
                #2;
                if (bus.o_ret_ready) begin
                    ok = 1'b1;
                    break;
                end
                if (bus.ss_pop) npop++;
                if (bus.o_violation && !seen) begin
                    seen = 1'b1;
                    chk("viol_cause", bus.o_viol_cause, e_cause);
                    chk("viol_target", bus.o_viol_target, t);
                    chk("viol_expected", bus.o_viol_expected, e_exp);
                    chk("viol_call_ready", bus.o_call_ready, 1'b0);
`ifdef SS_TRAP_HALT_EN
                    @(posedge clk); #1;
                    #2;
                    chk("halt_hold_viol", bus.o_violation, 1'b1);
                    chk("halt_hold_ready", bus.o_ret_ready, 1'b0);
                    bus.i_clear = 1'b1;
                    m_ovf = 1'b0; m_cause = 2'b00; m_tgt = 64'd0; m_exp = 64'd0;
`endif
                end
                @(posedge clk); #1;
                bus.i_clear = 1'b0;
            end
            if (!ok) fail_now("ret_complete");
            chk("ret_pops", npop, e_pop);
            chk("ret_violation", seen, e_viol);
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_pulse();
        bus.i_clear = 1'b1;
        @(posedge clk); #1;
        bus.i_clear = 1'b0;
        m_ovf = 1'b0; m_cause = 2'b00; m_tgt = 64'd0; m_exp = 64'd0;
        chk("clear_ovf", bus.o_overflow, 1'b0);
        chk("clear_cause", bus.o_viol_cause, 2'b00);
    endtask

    task automatic model_call(input logic [AW-1:0] a);
        bit e;
        e = (mstk.size() < 8);
        do_call(a, e);
        if (e) mstk.push_back(a);
        else   m_ovf = 1'b1;
        chk("m_ovf", bus.o_overflow, m_ovf);
    endtask

    task automatic model_ret(input logic [AW-1:0] t);
        bit e_pop, e_viol;
        logic [1:0] c;
        logic [AW-1:0] top;
        top = 64'd0; e_pop = 1'b0; e_viol = 1'b1; c = 2'b10;
        if (mstk.size() != 0) begin
            top = mstk.pop_back();
            e_pop = 1'b1;
            e_viol = (top != t);
            c = 2'b01;
        end
        if (e_viol) begin
            if (m_cnt < 255) m_cnt++;
            m_cause = c; m_tgt = t; m_exp = top;
        end else begin
            c = 2'b00;
        end
        do_ret(t, e_pop, e_viol, c, top);
        chk("m_cnt", bus.o_viol_cnt, m_cnt);
        chk("m_ovf", bus.o_overflow, m_ovf);
`ifndef SS_TRAP_HALT_EN
        chk("m_hold_cause", bus.o_viol_cause, m_cause);
        chk("m_hold_target", bus.o_viol_target, m_tgt);
        chk("m_hold_expected", bus.o_viol_expected, m_exp);
`endif
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        model_reset();
    endtask

    typedef struct {
        bit            is_ret;
        logic [AW-1:0] addr;
        bit            e_push;
        bit            e_pop;
        bit            e_viol;
        logic [1:0]    e_cause;
        logic [AW-1:0] e_exp;
        logic [CW-1:0] e_cnt;
        bit            e_ovf;
    } vec_t;

    vec_t tbl [16];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a;
        bus.i_call_valid = 1'b0; bus.i_call_addr = 64'd0;
        bus.i_ret_valid = 1'b0;  bus.i_ret_target = 64'd0;
        bus.i_clear = 1'b0;
        rstn = 1'b0;
        model_reset();

        tbl[0] = '{1'b0, 64'h1000, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0,    8'd0, 1'b0};
        tbl[1] = '{1'b0, 64'h2000, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0,    8'd0, 1'b0};
        tbl[2] = '{1'b1, 64'h2000, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0,    8'd0, 1'b0};
        tbl[3] = '{1'b1, 64'h1000, 1'b0, 1'b1, 1'b0, 2'b00, 64'h0,    8'd0, 1'b0};
        tbl[4] = '{1'b0, 64'h1000, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0,    8'd0, 1'b0};
        tbl[5] = '{1'b1, 64'h1004, 1'b0, 1'b1, 1'b1, 2'b01, 64'h1000, 8'd1, 1'b0};
        tbl[6] = '{1'b1, 64'h3000, 1'b0, 1'b0, 1'b1, 2'b10, 64'h0,    8'd2, 1'b0};
        for (int i = 7; i < 15; i++) begin
            tbl[i] = '{1'b0, 64'(i) << 8, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0, 8'd2, 1'b0};
        end
        tbl[15] = '{1'b0, 64'hF00, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0, 8'd2, 1'b1};

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_call_ready", bus.o_call_ready, 1'b0);
        chk("rst_ret_ready", bus.o_ret_ready, 1'b0);
        chk("rst_push", bus.ss_push, 1'b0);
        chk("rst_pop", bus.ss_pop, 1'b0);
        chk("rst_violation", bus.o_violation, 1'b0);
        chk("rst_cause", bus.o_viol_cause, 2'b00);
        chk("rst_overflow", bus.o_overflow, 1'b0);
        chk("rst_cnt", bus.o_viol_cnt, 8'd0);
        rstn = 1'b1;
        #2;
        chk("idle_ret_ready", bus.o_ret_ready, 1'b1);
        chk("idle_call_ready", bus.o_call_ready, 1'b1);
        @(posedge clk); #1;

        // Directed vector table.
        for (int i = 0; i < 16; i++) begin
            if (tbl[i].is_ret) begin
                do_ret(tbl[i].addr, tbl[i].e_pop, tbl[i].e_viol, tbl[i].e_cause, tbl[i].e_exp);
            end else begin
                do_call(tbl[i].addr, tbl[i].e_push);
            end
            chk($sformatf("tbl%0d_cnt", i), bus.o_viol_cnt, tbl[i].e_cnt);
            chk($sformatf("tbl%0d_ovf", i), bus.o_overflow, tbl[i].e_ovf);
        end
        clear_pulse();

        // Simultaneous call and return: return first, call two cycles later.
        do_reset();
        @(posedge clk); #1;
        do_call(64'h1000, 1'b1);
        bus.i_call_valid = 1'b1; bus.i_call_addr = 64'h5000;
        bus.i_ret_valid = 1'b1;  bus.i_ret_target = 64'h1000;
        #2;
        chk("sim_call_ready", bus.o_call_ready, 1'b0);
        chk("sim_ret_ready", bus.o_ret_ready, 1'b1);
        chk("sim_no_push", bus.ss_push, 1'b0);
        @(posedge clk); #1;
        bus.i_ret_valid = 1'b0;
        #2;
        chk("sim_cmp_pop", bus.ss_pop, 1'b1);
        chk("sim_cmp_call_ready", bus.o_call_ready, 1'b0);
        @(posedge clk); #1;
        #2;
        chk("sim_late_call_ready", bus.o_call_ready, 1'b1);
        chk("sim_late_push", bus.ss_push, 1'b1);
        chk("sim_late_wdata", bus.ss_wdata, 64'h5000);
        @(posedge clk); #1;
        bus.i_call_valid = 1'b0;
        chk("sim_stack_top", bus.ss_rdata, 64'h5000);
        chk("sim_no_viol", bus.o_violation, 1'b0);

        // Randomized transactions against the reference model.
        do_reset();
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(99, 0));
            if (r < 50) begin
                a = {$urandom, $urandom} & ~64'd1;
                model_call(a);
            end else if (r < 92) begin
                if (mstk.size() != 0 && $urandom_range(3, 0) != 0) a = mstk[$];
                else if (mstk.size() != 0) a = mstk[$] + 64'd4;
                else a = {$urandom, $urandom};
                model_ret(a);
            end else begin
                clear_pulse();
            end
        end

        // Drive the counter to saturation, then one more mismatch.
        for (int n = 0; n < 400 && m_cnt < 255; n++) begin
            model_ret(64'h3000);
        end
        while (mstk.size() != 0) model_ret(64'h3000);
        model_call(64'h1000);
        model_ret(64'h1004);
        chk("sat_cnt", bus.o_viol_cnt, 8'hFF);

        // Reset landing in CMP: no pop, everything back to zero.
        model_call(64'h7000);
        bus.i_ret_valid = 1'b1; bus.i_ret_target = 64'h7000;
        #2;
        chk("rcmp_accept", bus.o_ret_ready, 1'b1);
        @(posedge clk); #1;
        bus.i_ret_valid = 1'b0;
        chk("rcmp_in_cmp", bus.ss_pop, 1'b1);
        rstn = 1'b0;
        #1;
        chk("rcmp_no_pop", bus.ss_pop, 1'b0);
        chk("rcmp_ret_ready", bus.o_ret_ready, 1'b0);
        @(posedge clk); #1;
        chk("rcmp_pop_after", bus.ss_pop, 1'b0);
        chk("rcmp_push_after", bus.ss_push, 1'b0);
        chk("rcmp_violation", bus.o_violation, 1'b0);
        chk("rcmp_cause", bus.o_viol_cause, 2'b00);
        chk("rcmp_target", bus.o_viol_target, 64'd0);
        chk("rcmp_expected", bus.o_viol_expected, 64'd0);
        chk("rcmp_overflow", bus.o_overflow, 1'b0);
        chk("rcmp_cnt", bus.o_viol_cnt, 8'd0);
        chk("rcmp_call_ready", bus.o_call_ready, 1'b0);
        rstn = 1'b1;
        model_reset();
        #2;
        chk("rcmp_idle", bus.o_ret_ready, 1'b1);
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
